// File: rtl/de_selector_rr_pkg.sv
// Shared definitions for the registered 1-to-N demux with round-robin distribution.
package de_selector_rr_pkg;

    typedef enum logic {
        MODE_ADDR = 1'b0,
        MODE_RR   = 1'b1
    } mode_e;

    localparam int N_CH_DEF = 4;
    localparam int DW_DEF   = 8;

    // Widest channel count the onehot helper supports; callers truncate to N_CH.
    localparam int MAX_CH = 32;

    function automatic logic [MAX_CH-1:0] onehot(input int unsigned idx);
        logic [MAX_CH-1:0] vec;
        vec = '0;
        if (idx < MAX_CH) begin
            vec[idx] = 1'b1;
        end
        return vec;
    endfunction

endpackage

// File: rtl/de_selector_rr_if.sv
// Producer-side and consumer-side handshake bundle of the demux.
interface de_selector_rr_if #(
    parameter int N_CH = 4,
    parameter int DW   = 8
);
    localparam int SW = $clog2(N_CH);

    logic            iMode;
    logic [SW-1:0]   iSel;
    logic [DW-1:0]   iData;
    logic            iValid;
    logic            oReady;
    logic [DW-1:0]   oData;
    logic [N_CH-1:0] oValid;
    logic [N_CH-1:0] iReady;
    logic [SW-1:0]   oPtr;
    logic            oErr;

    modport master (
        output iMode, iSel, iData, iValid, iReady,
        input  oReady, oData, oValid, oPtr, oErr
    );

    modport slave (
        input  iMode, iSel, iData, iValid, iReady,
        output oReady, oData, oValid, oPtr, oErr
    );
endinterface

// File: rtl/de_selector_rr_rr_pointer.sv
// Modulo-N wrap counter with enable; reusable as an arbiter pointer.
module rr_pointer #(
    parameter int N  = 4,
    parameter int SW = $clog2(N)
) (
    input  logic          iClk,
    input  logic          iRst_n,
    input  logic          iEn,
    output logic [SW-1:0] oPtr
);

    logic [SW-1:0] ptr;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            ptr <= '0;
        end else if (iEn) begin
            ptr <= (ptr == SW'(N - 1)) ? '0 : ptr + 1'b1;
        end
    end

    assign oPtr = ptr;

endmodule

// File: rtl/de_selector_rr.sv
// Registered 1-to-N demux: one holding register, addressed or round-robin routing.
module de_selector_rr
    import de_selector_rr_pkg::*;
#(
    parameter int N_CH = N_CH_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic           iClk,
    input  logic           iRst_n,
    de_selector_rr_if.slave bus
);

    localparam int SW = $clog2(N_CH);

    logic            full;
    logic [SW-1:0]   dest;
    logic [DW-1:0]   dataReg;
    logic            errReg;
    logic [SW-1:0]   ptr;
    logic            destReady;
    logic            acc;
    logic            drn;
    logic            selLegal;
    logic            rrMode;
    logic [SW-1:0]   newDest;

    // Only the destination consumer's ready matters; dest is always a legal channel.
    assign destReady = bus.iReady[dest];
    assign rrMode    = (bus.iMode == MODE_RR);
    assign selLegal  = rrMode || (int'(bus.iSel) < N_CH);
    assign newDest   = rrMode ? ptr : bus.iSel;

    assign bus.oReady = !full || destReady;
    assign acc        = bus.iValid && bus.oReady;
    assign drn        = full && destReady;

    rr_pointer #(.N(N_CH), .SW(SW)) uPtr (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iEn    (acc && rrMode),
        .oPtr   (ptr)
    );

    // A legal accept reloads even while draining; an illegal one only drops the word.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            full    <= 1'b0;
            dest    <= '0;
            dataReg <= '0;
            errReg  <= 1'b0;
        end else begin
            errReg <= acc && !selLegal;
            if (acc && selLegal) begin
                dataReg <= bus.iData;
                dest    <= newDest;
                full    <= 1'b1;
            end else if (drn) begin
                full <= 1'b0;
            end
        end
    end

    assign bus.oData  = dataReg;
    assign bus.oValid = full ? N_CH'(onehot(int'(dest))) : '0;
    assign bus.oPtr   = ptr;
    assign bus.oErr   = errReg;

endmodule

// File: tb/tb_de_selector_rr.sv
// Directed bench for de_selector_rr: a 4-channel and a 3-channel instance.
module tb_de_selector_rr;

    logic iClk;
    logic iRst_n;
    int   vectorCount;
    int   missCount;

    de_selector_rr_if #(.N_CH(4), .DW(8)) bus4 ();
    de_selector_rr_if #(.N_CH(3), .DW(8)) bus3 ();

    de_selector_rr #(.N_CH(4), .DW(8)) dut4 (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .bus    (bus4.slave)
    );

    de_selector_rr #(.N_CH(3), .DW(8)) dut3 (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .bus    (bus3.slave)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic mode, input logic [1:0] sel,
                                 input logic [7:0] data, input logic valid,
                                 input logic [3:0] ready);
        bus4.iMode  = mode;
        bus4.iSel   = sel;
        bus4.iData  = data;
        bus4.iValid = valid;
        bus4.iReady = ready;
    endtask

    task automatic applyStimulus3(input logic mode, input logic [1:0] sel,
                                  input logic [7:0] data, input logic valid,
                                  input logic [2:0] ready);
        bus3.iMode  = mode;
        bus3.iSel   = sel;
        bus3.iData  = data;
        bus3.iValid = valid;
        bus3.iReady = ready;
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    logic [3:0] rrValid [6];
    logic [1:0] rrPtr   [6];

    initial begin
        vectorCount = 0;
        missCount   = 0;
        rrValid = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        rrPtr   = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};

        // Reset with random inputs toggling
        iRst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'($urandom), 2'($urandom), 8'($urandom), 1'($urandom), 4'($urandom));
            applyStimulus3(1'($urandom), 2'($urandom), 8'($urandom), 1'($urandom), 3'($urandom));
            tick();
        end
        @(negedge iClk);
        iRst_n = 1'b1;
        #1;
        checkOutput("rst_valid", 32'(bus4.oValid), 32'h0);
        checkOutput("rst_ready", 32'(bus4.oReady), 32'h1);
        checkOutput("rst_ptr",   32'(bus4.oPtr),   32'h0);
        checkOutput("rst_err",   32'(bus4.oErr),   32'h0);
        checkOutput("rst_data",  32'(bus4.oData),  32'h0);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 4'b1111);
        applyStimulus3(1'b0, 2'd0, 8'h00, 1'b0, 3'b111);
        tick();

        // Addressed mode
        applyStimulus(1'b0, 2'd2, 8'hA5, 1'b1, 4'b1111);
        tick();
        checkOutput("addr_valid", 32'(bus4.oValid), 32'h4);
        checkOutput("addr_data",  32'(bus4.oData),  32'hA5);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 4'b1111);
        tick();
        checkOutput("addr_drain", 32'(bus4.oValid), 32'h0);
        checkOutput("addr_keep",  32'(bus4.oData),  32'hA5);

        // Back-pressure; non-destination ready bits must be ignored
        applyStimulus(1'b0, 2'd1, 8'h3C, 1'b1, 4'b0000);
        tick();
        applyStimulus(1'b0, 2'd3, 8'h99, 1'b1, 4'b1101);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_valid", 32'(bus4.oValid), 32'h2);
            checkOutput("bp_ready", 32'(bus4.oReady), 32'h0);
            checkOutput("bp_data",  32'(bus4.oData),  32'h3C);
            tick();
        end
        applyStimulus(1'b0, 2'd3, 8'h7E, 1'b1, 4'b0010);
        #1;
        checkOutput("bp_release_ready", 32'(bus4.oReady), 32'h1);
        tick();
        checkOutput("swap_valid", 32'(bus4.oValid), 32'h8);
        checkOutput("swap_data",  32'(bus4.oData),  32'h7E);
        checkOutput("swap_ptr",   32'(bus4.oPtr),   32'h0);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 4'b1111);
        tick();
        checkOutput("swap_drain", 32'(bus4.oValid), 32'h0);

        // Round-robin, back-to-back
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 2'd0, 8'(i + 1), 1'b1, 4'b1111);
            tick();
            checkOutput("rr_valid", 32'(bus4.oValid), 32'(rrValid[i]));
            checkOutput("rr_ptr",   32'(bus4.oPtr),   32'(rrPtr[i]));
            checkOutput("rr_data",  32'(bus4.oData),  32'(i + 1));
        end

        // Mode switch: pointer holds in addressed mode, resumes in round-robin
        applyStimulus(1'b0, 2'd0, 8'h11, 1'b1, 4'b1111);
        tick();
        checkOutput("sw_addr_valid", 32'(bus4.oValid), 32'h1);
        checkOutput("sw_addr_ptr",   32'(bus4.oPtr),   32'h2);
        applyStimulus(1'b1, 2'd0, 8'h22, 1'b1, 4'b1111);
        tick();
        checkOutput("sw_rr_valid", 32'(bus4.oValid), 32'h4);
        checkOutput("sw_rr_ptr",   32'(bus4.oPtr),   32'h3);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 4'b1111);
        tick();

        // Asynchronous reset while holding a word
        applyStimulus(1'b0, 2'd2, 8'h44, 1'b1, 4'b0000);
        tick();
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 4'b0000);
        checkOutput("ar_pre_valid", 32'(bus4.oValid), 32'h4);
        checkOutput("ar_pre_ptr",   32'(bus4.oPtr),   32'h3);
        #2;
        iRst_n = 1'b0;
        #1;
        checkOutput("ar_valid", 32'(bus4.oValid), 32'h0);
        checkOutput("ar_ptr",   32'(bus4.oPtr),   32'h0);
        checkOutput("ar_data",  32'(bus4.oData),  32'h0);
        @(negedge iClk);
        iRst_n = 1'b1;
        tick();

        // Illegal select on the 3-channel instance
        applyStimulus3(1'b1, 2'd0, 8'h10, 1'b1, 3'b111);
        tick();
        checkOutput("n3_rr_valid", 32'(bus3.oValid), 32'h1);
        checkOutput("n3_rr_ptr",   32'(bus3.oPtr),   32'h1);
        applyStimulus3(1'b0, 2'd3, 8'h55, 1'b1, 3'b111);
        #1;
        checkOutput("ill_ready", 32'(bus3.oReady), 32'h1);
        tick();
        applyStimulus3(1'b0, 2'd0, 8'h00, 1'b0, 3'b111);
        checkOutput("ill_err",   32'(bus3.oErr),   32'h1);
        checkOutput("ill_valid", 32'(bus3.oValid), 32'h0);
        checkOutput("ill_ptr",   32'(bus3.oPtr),   32'h1);
        checkOutput("ill_data",  32'(bus3.oData),  32'h10);
        tick();
        checkOutput("ill_err_end", 32'(bus3.oErr), 32'h0);

        // Illegal accept while draining a held word
        applyStimulus3(1'b0, 2'd1, 8'h66, 1'b1, 3'b000);
        tick();
        checkOutput("ill2_held", 32'(bus3.oValid), 32'h2);
        applyStimulus3(1'b0, 2'd3, 8'h77, 1'b1, 3'b010);
        tick();
        applyStimulus3(1'b0, 2'd0, 8'h00, 1'b0, 3'b000);
        checkOutput("ill2_err",   32'(bus3.oErr),   32'h1);
        checkOutput("ill2_valid", 32'(bus3.oValid), 32'h0);
        checkOutput("ill2_data",  32'(bus3.oData),  32'h66);
        tick();
        checkOutput("ill2_err_end", 32'(bus3.oErr), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
